shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer and arbiter for the single shared 16-bit Shifter.
  - Mode 0 = SLL, Mode 1 = SRA.
  - 4-bit shift amount, combinational Shift_Out.
- Accepts shift requests from two requesters (e.g. EX-stage ALU and address/immediate path) with round-robin arbitration.
- Drives the Shifter's inputs and captures its output.
- Synthesizes ROR from three Shifter passes, so the datapath needs no separate rotator.

Parameters:
- FIXED_PRIO, 0, 1 = requester 0 always wins ties; 0 = round-robin.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  2  per-requester request valid; bit i belongs to requester i
- req_op0  in  2  requester 0 opcode: 00 SLL, 01 SRA, 10 ROR, 11 illegal
- req_op1  in  2  requester 1 opcode, same encoding
- req_data0  in  16  requester 0 operand
- req_data1  in  16  requester 1 operand
- req_amt0  in  4  requester 0 shift amount
- req_amt1  in  4  requester 1 shift amount
- req_ready  out  2  per-requester accept; a transaction transfers when valid&ready
- sh_in  out  16  to Shifter Shift_In
- sh_val  out  4  to Shifter Shift_Val
- sh_mode  out  1  to Shifter Mode
- sh_out  in  16  from Shifter Shift_Out
- res_valid  out  1  one-cycle result strobe
- res_data  out  16  result, valid only with res_valid
- res_id  out  1  requester that issued the result
- res_err  out  1  illegal opcode flag, qualified by res_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - res_valid, res_data, res_id, res_err, busy, sh_in, sh_val, sh_mode all go to 0.
  - RR pointer is set to "last granted = 1".
  - An in-flight operation is discarded and produces no result.
- States: IDLE, P1, P2, P3, DONE.
- req_ready:
  - Combinational; nonzero only in IDLE; at most one bit set.
  - Goes to the granted requester among the valid ones.
- Arbitration:
  - Single requester valid: it is granted.
  - Both valid, round-robin: the requester not granted last wins.
  - Both valid, FIXED_PRIO=1: requester 0 wins.
  - The pointer updates only on accept.
- On accept (edge k):
  - Latch op, data (D), amt (n), id.
  - SLL/SRA/ROR go to P1; op 11 goes to DONE.
- P1 (SLL/SRA):
  - sh_in=D, sh_val=n, sh_mode=op[0].
  - Capture sh_out into the result register; go to DONE.
- ROR, res = (D logically >> n) | (D << (16-n)):
  - P1: sh_in=D, sh_mode=0, sh_val=(-n mod 16). Capture sh_out into LO.
  - P2: sh_in=D, sh_mode=1, sh_val=n. Capture sh_out into HI.
  - P3: sh_in=16'hFFFF, sh_mode=0, sh_val=(-n mod 16), giving mask M. Result = (HI & ~M) | LO.
  - Go to DONE.
  - n=0 needs no special case: LO=D, M=FFFF, result=D.
- DONE:
  - res_valid=1 for exactly one cycle with res_data, res_id, res_err.
  - Next state is IDLE.
  - Op 11: res_data=0x0000, res_err=1.
- Latency, accept edge to res_valid high:
  - SLL/SRA: 2 cycles.
  - ROR: 4 cycles.
  - Illegal: 1 cycle.
- Throughput: a new accept is possible in the IDLE cycle following DONE. Back-to-back accepts are never allowed.
- No result backpressure; the consumer must take res_* in the strobe cycle.
- sh_* outputs are 0 in IDLE and DONE.
- Requesters must hold op/data/amt stable while valid and not ready. Deasserting valid before accept is allowed and cancels the request.

Optional Feature:
- Macro SHIFT_SEQ_ROR_EN.
  - Defined: op 10 performs ROR as above.
  - Undefined: op 10 is treated exactly as op 11 (DONE in 1 cycle, res_data=0, res_err=1). P2/P3 logic and the LO/HI registers are not compiled.

Test Plan:
- SLL: req0 D=0x00F3, n=4, op 00 -> res_data=0x0F30, res_id=0, res_err=0, res_valid exactly 2 cycles after accept, single-cycle pulse.
- SRA: req1 D=0x8010, n=4, op 01 -> 0xF801, res_id=1. Then D=0x7FFF, n=15 -> 0x0000.
- ROR (SHIFT_SEQ_ROR_EN defined), each with 4-cycle latency:
  - D=0x8001, n=1 -> 0xC000
  - D=0x1234, n=4 -> 0x4123
  - D=0x1234, n=0 -> 0x1234
  - D=0xABCD, n=15 -> 0x579B
- Arbitration: both valid out of reset -> grants 0,1,0,1 on successive accepts. req_ready is never high outside IDLE. FIXED_PRIO=1 -> always 0 while both are valid.
- Illegal op 11 (and op 10 with macro undefined) -> res_valid 1 cycle after accept, res_data=0x0000, res_err=1.
- Reset asserted during ROR P2 -> busy and res_valid go 0 immediately, no result is ever emitted. The following req1 SLL D=0x0001, n=15 -> 0x8000 normally.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl
// Purpose  : Arbitrates two requesters onto one shared combinational 16-bit
//            Shifter (mode 0 = SLL, mode 1 = SRA) and sequences the passes.
//            A rotate-right is built from three Shifter passes, so the
//            datapath never needs a dedicated rotator.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: SHIFT_SEQ_ROR_EN
//   defined   : opcode 2'b10 performs ROR (three passes)
//   undefined : opcode 2'b10 is illegal, same as 2'b11; the ROR passes and
//               their LO/HI holding registers are not built
// ----------------------------------------------------------------------------
// Parameters:
//   FIXED_PRIO : 1 = requester 0 always wins when both are valid
//                0 = round-robin (the requester not granted last wins)
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   req_valid  in   2   per-requester request valid (bit i = requester i)
//   req_op0/1  in   2   opcode: 00 SLL, 01 SRA, 10 ROR, 11 illegal
//   req_data0/1 in 16   operand
//   req_amt0/1 in   4   shift amount
//   req_ready  out  2   per-requester accept (one-hot or zero, IDLE only)
//   sh_in      out 16   to Shifter Shift_In
//   sh_val     out  4   to Shifter Shift_Val
//   sh_mode    out  1   to Shifter Mode
//   sh_out     in  16   from Shifter Shift_Out
//   res_valid  out  1   one-cycle result strobe
//   res_data   out 16   result, qualified by res_valid
//   res_id     out  1   requester that issued the result
//   res_err    out  1   illegal-opcode flag, qualified by res_valid
//   busy       out  1   high whenever the sequencer is not IDLE
// ============================================================================
module shift_seq_ctrl #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_op0,
  input  logic [1:0]  req_op1,
  input  logic [15:0] req_data0,
  input  logic [15:0] req_data1,
  input  logic [3:0]  req_amt0,
  input  logic [3:0]  req_amt1,
  output logic [1:0]  req_ready,
  output logic [15:0] sh_in,
  output logic [3:0]  sh_val,
  output logic        sh_mode,
  input  logic [15:0] sh_out,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_id,
  output logic        res_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;

  // Latched transaction
  logic        mode_q;      // Shifter mode for single-pass ops (op[0])
  logic [15:0] data_q;
  logic [3:0]  amt_q;
  logic        id_q;
  logic        err_q;
  logic [15:0] res_q;
  logic        last_q;      // requester granted on the most recent accept

`ifdef SHIFT_SEQ_ROR_EN
  logic        ror_q;
  logic [15:0] lo_q;        // D << (16-n)
  logic [15:0] hi_q;        // D >>> n (arithmetic; sign fill masked later)
  logic [3:0]  neg_amt;     // (-n) mod 16
`endif

  // Arbitration / selected request
  logic        grant_id;
  logic        any_valid;
  logic [1:0]  sel_op;
  logic [15:0] sel_data;
  logic [3:0]  sel_amt;
  logic        sel_illegal;

  // --------------------------------------------------------------------------
  // Arbiter: pure function of valids and the last-granted pointer
  // --------------------------------------------------------------------------
  always_comb begin
    any_valid = |req_valid;
    grant_id  = 1'b0;
    if (req_valid == 2'b10) begin
      grant_id = 1'b1;
    end else if (req_valid == 2'b11) begin
      grant_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end
  end

  assign sel_op   = grant_id ? req_op1   : req_op0;
  assign sel_data = grant_id ? req_data1 : req_data0;
  assign sel_amt  = grant_id ? req_amt1  : req_amt0;

`ifdef SHIFT_SEQ_ROR_EN
  assign sel_illegal = (sel_op == 2'b11);
  assign neg_amt     = 4'd0 - amt_q;
`else
  // Without the rotate feature, any op with bit 1 set is unsupported
  assign sel_illegal = sel_op[1];
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and Shifter drive
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    sh_in     = 16'h0000;
    sh_val    = 4'd0;
    sh_mode   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          req_ready = grant_id ? 2'b10 : 2'b01;
          state_d   = sel_illegal ? S_DONE : S_P1;
        end
      end

      S_P1: begin
        sh_in = data_q;
`ifdef SHIFT_SEQ_ROR_EN
        if (ror_q) begin
          // LO = D << (16-n); n=0 yields shift by 0, i.e. LO = D
          sh_val  = neg_amt;
          sh_mode = 1'b0;
          state_d = S_P2;
        end else begin
          sh_val  = amt_q;
          sh_mode = mode_q;
          state_d = S_DONE;
        end
`else
        sh_val  = amt_q;
        sh_mode = mode_q;
        state_d = S_DONE;
`endif
      end

`ifdef SHIFT_SEQ_ROR_EN
      S_P2: begin
        // HI = D >>> n; top n bits carry sign copies, cleared in P3
        sh_in   = data_q;
        sh_val  = amt_q;
        sh_mode = 1'b1;
        state_d = S_P3;
      end

      S_P3: begin
        // Mask M = FFFF << (16-n): ones exactly where HI has sign fill
        sh_in   = 16'hFFFF;
        sh_val  = neg_amt;
        sh_mode = 1'b0;
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction latch and result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      data_q <= 16'h0000;
      amt_q  <= 4'd0;
      id_q   <= 1'b0;
      err_q  <= 1'b0;
      res_q  <= 16'h0000;
      last_q <= 1'b1;   // so requester 0 wins the first tie
`ifdef SHIFT_SEQ_ROR_EN
      ror_q  <= 1'b0;
      lo_q   <= 16'h0000;
      hi_q   <= 16'h0000;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            mode_q <= sel_op[0];
            data_q <= sel_data;
            amt_q  <= sel_amt;
            id_q   <= grant_id;
            last_q <= grant_id;
            err_q  <= sel_illegal;
            // Illegal ops skip the passes and report zero
            res_q  <= 16'h0000;
`ifdef SHIFT_SEQ_ROR_EN
            ror_q  <= (sel_op == 2'b10);
`endif
          end
        end

        S_P1: begin
`ifdef SHIFT_SEQ_ROR_EN
          if (ror_q) begin
            lo_q <= sh_out;
          end else begin
            res_q <= sh_out;
          end
`else
          res_q <= sh_out;
`endif
        end

`ifdef SHIFT_SEQ_ROR_EN
        S_P2: begin
          hi_q <= sh_out;
        end

        S_P3: begin
          res_q <= (hi_q & ~sh_out) | lo_q;
        end
`endif

        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Result outputs: decoded from state so reset clears them immediately
  // --------------------------------------------------------------------------
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_valid ? res_q : 16'h0000;
  assign res_id    = res_valid & id_q;
  assign res_err   = res_valid & err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire
